// File: rtl/aurora_tx_frame_distributor.sv
// Aurora Tx frame distributor.
// Stripes a single 64-bit word stream across four Aurora lanes in lane order
// 0..3. Each lane sees one 66-bit block (64-bit payload + 2-bit sync). Lanes are
// filled with idle control blocks when no complete or terminated frame is
// staged, and a channel-bonding control frame is inserted every CB_PERIOD
// frames. Lane registers only advance when all four lanes request together.
//
// Handshake: a word transfers on every rising clk edge where s_valid && s_ready
// are both high. s_valid/s_data/s_last must be held stable while s_valid is high
// and s_ready is low. s_ready does not depend on s_valid. s_last is qualified by
// s_valid and marks the final word of a packet, which forces the partial frame
// out (idle-padded) at the next frame event.
module aurora_tx_frame_distributor #(
    parameter int unsigned CB_PERIOD = 64,
    parameter logic [63:0] IDLE_WORD = 64'h7800_0000_0000_0000,
    parameter logic [63:0] CB_WORD   = 64'h7840_0000_0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    input  logic [3:0]  data_next,
    output logic [63:0] data_out [4],
    output logic [1:0]  sync_out [4],
    output logic        lane_mismatch
);

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    // cb_cnt only has to hold 0..CB_PERIOD-1.
    localparam int unsigned    CB_W    = (CB_PERIOD > 2) ? $clog2(CB_PERIOD) : 1;
    localparam bit             CB_EN   = (CB_PERIOD != 0);
    localparam logic [CB_W-1:0] CB_LAST = CB_EN ? CB_W'(CB_PERIOD - 1) : '0;

    logic [63:0]     stage_q [4];
    logic [63:0]     stage_d [4];
    logic [2:0]      cnt_q, cnt_d;
    logic            pad_pending_q, pad_pending_d;
    logic [CB_W-1:0] cb_cnt_q, cb_cnt_d;
    logic            mismatch_q, mismatch_d;
    logic            out_en_q;
    logic [63:0]     data_q [4];
    logic [63:0]     data_d [4];
    logic [1:0]      sync_q [4];
    logic [1:0]      sync_d [4];

    logic accept;
    logic frame_ev;
    logic bad_req;
    logic cb_hit;
    logic stage_ready;

    // out_en_q keeps s_ready low while in reset and for the release cycle.
    assign s_ready     = out_en_q && (cnt_q < 3'd4) && !pad_pending_q;
    assign accept      = s_valid && s_ready;
    assign frame_ev    = (data_next == 4'b1111);
    assign bad_req     = (data_next != 4'b0000) && !frame_ev;
    assign cb_hit      = CB_EN && (cb_cnt_q == CB_LAST);
    assign stage_ready = (cnt_q == 3'd4) || pad_pending_q;

    assign data_out      = data_q;
    assign sync_out      = sync_q;
    assign lane_mismatch = mismatch_q;

    // Next-state: stage accepts, frame loading with CB > staged > idle priority,
    // and the sticky request-disagreement flag.
    always_comb begin
        stage_d       = stage_q;
        cnt_d         = cnt_q;
        pad_pending_d = pad_pending_q;
        cb_cnt_d      = cb_cnt_q;
        mismatch_d    = mismatch_q;
        data_d        = data_q;
        sync_d        = sync_q;

        // An accept never coincides with a staged-frame load (s_ready is low
        // then), so it can safely be applied before the frame decision.
        if (accept) begin
            stage_d[cnt_q[1:0]] = s_data;
            cnt_d               = cnt_q + 3'd1;
            if (s_last) begin
                pad_pending_d = 1'b1;
            end
        end

        if (frame_ev) begin
            if (cb_hit) begin
                // Bonding frame leaves the stage alone; data waits one frame.
                for (int i = 0; i < 4; i++) begin
                    data_d[i] = CB_WORD;
                    sync_d[i] = SYNC_CTRL;
                end
                cb_cnt_d = '0;
            end else begin
                if (stage_ready) begin
                    for (int i = 0; i < 4; i++) begin
                        if (i < int'(cnt_q)) begin
                            data_d[i] = stage_q[i];
                            sync_d[i] = SYNC_DATA;
                        end else begin
                            data_d[i] = IDLE_WORD;
                            sync_d[i] = SYNC_CTRL;
                        end
                    end
                    cnt_d         = 3'd0;
                    pad_pending_d = 1'b0;
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        data_d[i] = IDLE_WORD;
                        sync_d[i] = SYNC_CTRL;
                    end
                end
                if (CB_EN) begin
                    cb_cnt_d = cb_cnt_q + CB_W'(1);
                end
            end
        end

        if (bad_req) begin
            mismatch_d = 1'b1;
        end
    end

    // State registers; reset drops staged words and returns lanes to idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                stage_q[i] <= '0;
                data_q[i]  <= IDLE_WORD;
                sync_q[i]  <= SYNC_CTRL;
            end
            cnt_q         <= 3'd0;
            pad_pending_q <= 1'b0;
            cb_cnt_q      <= '0;
            mismatch_q    <= 1'b0;
            out_en_q      <= 1'b0;
        end else begin
            stage_q       <= stage_d;
            data_q        <= data_d;
            sync_q        <= sync_d;
            cnt_q         <= cnt_d;
            pad_pending_q <= pad_pending_d;
            cb_cnt_q      <= cb_cnt_d;
            mismatch_q    <= mismatch_d;
            out_en_q      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aurora_tx_frame_distributor.sv
// Bench for aurora_tx_frame_distributor (CB_PERIOD = 4).
// The driver applies one cycle of stimulus per call, checks s_ready and
// lane_mismatch against a queue-based reference model, and pushes the expected
// lane frame for every edge that must load the lanes. The monitor pops and
// compares on those edges and checks that lanes hold on all other edges.
module tb_aurora_tx_frame_distributor;

    localparam int          CBP  = 4;
    localparam int          FW   = 264;
    localparam logic [63:0] IDLE = 64'h7800_0000_0000_0000;
    localparam logic [63:0] CBW  = 64'h7840_0000_0000_0000;
    localparam logic [3:0]  F    = 4'b1111;

    logic        clk;
    logic        reset;
    logic [63:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [3:0]  data_next;
    logic [63:0] data_out [4];
    logic [1:0]  sync_out [4];
    logic        lane_mismatch;

    aurora_tx_frame_distributor #(
        .CB_PERIOD (CBP),
        .IDLE_WORD (IDLE),
        .CB_WORD   (CBW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .data_next     (data_next),
        .data_out      (data_out),
        .sync_out      (sync_out),
        .lane_mismatch (lane_mismatch)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        reset     = 1'b0;
        s_data    = '0;
        s_valid   = 1'b0;
        s_last    = 1'b0;
        data_next = 4'b0000;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [FW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Words waiting for a frame, whether a packet end forces them out, frames
    // since reset (every CBP-th frame is a bonding frame), and sticky error.
    logic [63:0] m_stage[$];
    logic        m_pad    = 1'b0;
    int          m_frames = 0;
    logic        m_mis    = 1'b0;
    logic        m_out_en = 1'b0;

    function automatic logic [FW-1:0] uniform_frame(input logic [63:0] w);
        logic [FW-1:0] f;
        for (int i = 0; i < 4; i++) f[i*66 +: 66] = {2'b10, w};
        return f;
    endfunction

    task automatic model_edge(input logic rst_n, input logic acc, input logic [63:0] d,
                              input logic l, input logic [3:0] dn);
        logic [FW-1:0] f;
        if (!rst_n) begin
            m_stage.delete();
            m_pad    = 1'b0;
            m_frames = 0;
            m_mis    = 1'b0;
            m_out_en = 1'b0;
            exp_q.push_back(uniform_frame(IDLE));
            return;
        end
        m_out_en = 1'b1;
        if (dn == F) begin
            m_frames++;
            if (m_frames % CBP == 0) begin
                exp_q.push_back(uniform_frame(CBW));
            end else if (m_stage.size() == 4 || m_pad) begin
                f = uniform_frame(IDLE);
                for (int i = 0; i < m_stage.size(); i++) f[i*66 +: 66] = {2'b01, m_stage[i]};
                m_stage.delete();
                m_pad = 1'b0;
                exp_q.push_back(f);
            end else begin
                exp_q.push_back(uniform_frame(IDLE));
            end
        end else if (dn != 4'b0000) begin
            m_mis = 1'b1;
        end
        if (acc) begin
            m_stage.push_back(d);
            if (l) m_pad = 1'b1;
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic rst_n, input logic v, input logic [63:0] d,
                        input logic l, input logic [3:0] dn);
        logic m_ready;
        logic acc;
        @(negedge clk);
        reset     = rst_n;
        s_valid   = v;
        s_data    = d;
        s_last    = l;
        data_next = dn;
        #1;
        m_ready = m_out_en && (m_stage.size() < 4) && !m_pad;
        check("s_ready", FW'(s_ready), FW'(m_ready));
        check("lane_mismatch", FW'(lane_mismatch), FW'(m_mis));
        acc = v && m_ready;
        @(posedge clk);
        model_edge(rst_n, acc, d, l, dn);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic [FW-1:0] act;
        logic [FW-1:0] last_exp;
        logic [FW-1:0] e;
        logic [3:0]    dn_s;
        logic          rst_s;
        last_exp = uniform_frame(IDLE);
        @(negedge clk);
        forever begin
            @(posedge clk);
            dn_s  = data_next;
            rst_s = reset;
            #1;
            for (int i = 0; i < 4; i++) act[i*66 +: 66] = {sync_out[i], data_out[i]};
            if (!rst_s || dn_s == F) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL frame: got %h expected <no entry queued>", act);
                end else begin
                    e = exp_q.pop_front();
                    check("frame", act, e);
                    last_exp = e;
                end
            end else begin
                check("hold", act, last_exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset hold, release with no requests.
        repeat (4) step(0, 0, '0, 0, 4'b0000);
        repeat (3) step(1, 0, '0, 0, 4'b0000);

        // Full frame 0x11..0x44, then an empty-stage frame.
        step(1, 1, 64'h11, 0, 4'b0000);
        step(1, 1, 64'h22, 0, 4'b0000);
        step(1, 1, 64'h33, 0, 4'b0000);
        step(1, 1, 64'h44, 0, 4'b0000);
        step(1, 0, '0, 0, F);
        step(1, 0, '0, 0, 4'b0000);
        step(1, 0, '0, 0, F);

        // Short packet padded with idle; 0xB1 stalls until the frame goes out.
        step(1, 1, 64'hA1, 0, 4'b0000);
        step(1, 1, 64'hA2, 1, 4'b0000);
        repeat (3) step(1, 1, 64'hB1, 0, 4'b0000);
        step(1, 1, 64'hB1, 0, F);
        step(1, 1, 64'hB1, 0, 4'b0000);
        step(1, 0, '0, 0, 4'b0000);

        // Continuous input with a frame every third cycle; bonding frames interleave.
        for (int i = 0; i < 36; i++) step(1, 1, rnd64(), 0, (i % 3 == 2) ? F : 4'b0000);
        step(1, 0, '0, 1'b0, 4'b0000);

        // Disagreeing requests: sticky error, lanes hold, frames continue afterwards.
        step(1, 0, '0, 0, 4'b0101);
        repeat (3) step(1, 1, rnd64(), 0, 4'b0000);
        step(1, 0, '0, 0, F);
        step(1, 0, '0, 0, F);
        repeat (2) step(0, 0, '0, 0, 4'b0000);
        step(1, 0, '0, 0, 4'b0000);

        // Reset with three words staged; first frame after release is idle.
        for (int i = 0; i < 3; i++) step(1, 1, rnd64(), 0, 4'b0000);
        repeat (2) step(0, 0, '0, 0, 4'b0000);
        step(1, 0, '0, 0, 4'b0000);
        step(1, 0, '0, 0, F);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            int r;
            logic [3:0] dn;
            r  = $urandom_range(0, 99);
            dn = (r < 30) ? F : ((r == 99) ? 4'b0110 : 4'b0000);
            step(1, 1'($urandom_range(0, 1)), rnd64(), ($urandom_range(0, 5) == 0), dn);
        end

        step(1, 0, '0, 0, 4'b0000);
        repeat (2) @(negedge clk);
        check("queue_drained", FW'(exp_q.size()), FW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
